// File: rtl/usb_rst_sequencer.sv
// USB controller reset sequencer with an Avalon-MM register slave.
// Drives a timed active-low reset pulse followed by a recovery wait.
module usb_rst_sequencer #(
   parameter logic [15:0] PULSE_DEFAULT = 16'd50000,
   parameter logic [15:0] WAIT_DEFAULT  = 16'd50000,
   parameter bit          AUTO_START    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic [1:0]  address,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        usb_rst_n,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ASSERT  = 2'b01,
      S_RECOVER = 2'b10,
      S_UNUSED  = 2'b11
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [15:0] pulse_len, wait_len;
   logic [15:0] wait_lat, wait_lat_nxt;
   logic        done, done_nxt;
   logic        force_r, force_nxt;
   logic        irq_en, irq_en_nxt;
   logic        armed;
   logic        usb_rst_n_nxt;

   logic wr_en, wr_ctrl, wr_status, wr_pulse, wr_wait;
   logic start_req;
   logic busy;
   logic unused_wdata;

   assign wr_en     = chipselect & ~write_n;
   assign wr_ctrl   = wr_en && (address == 2'd0);
   assign wr_status = wr_en && (address == 2'd1);
   assign wr_pulse  = wr_en && (address == 2'd2);
   assign wr_wait   = wr_en && (address == 2'd3);

   // The automatic sequence is requested exactly once, on the first edge after reset release.
   assign start_req = (wr_ctrl & writedata[0]) | (AUTO_START && !armed);

   assign busy         = (state == S_ASSERT) || (state == S_RECOVER);
   assign irq          = done & irq_en;
   assign unused_wdata = ^writedata[31:16];

   function automatic logic [15:0] len_m1(input logic [15:0] len);
      return (len == 16'd0) ? 16'd0 : len - 16'd1;
   endfunction

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      wait_lat_nxt = wait_lat;
      done_nxt     = done;
      force_nxt    = force_r;
      irq_en_nxt   = irq_en;

      if (wr_ctrl) begin
         force_nxt  = writedata[1];
         irq_en_nxt = writedata[2];
      end
      if (wr_status && writedata[1])
         done_nxt = 1'b0;

      case (state)
         S_ASSERT: begin
            if (cnt == 16'd0) begin
               state_nxt = S_RECOVER;
               cnt_nxt   = len_m1(wait_lat);
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         S_RECOVER: begin
            // Completion wins over a simultaneous write-1-to-clear.
            if (cnt == 16'd0) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            if (start_req) begin
               state_nxt    = S_ASSERT;
               cnt_nxt      = len_m1(pulse_len);
               wait_lat_nxt = wait_len;
               done_nxt     = 1'b0;
            end
         end
      endcase

      usb_rst_n_nxt = !((state_nxt == S_ASSERT) || force_nxt);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         wait_lat  <= '0;
         done      <= 1'b0;
         force_r   <= 1'b0;
         irq_en    <= 1'b0;
         armed     <= 1'b0;
         usb_rst_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wait_lat  <= wait_lat_nxt;
         done      <= done_nxt;
         force_r   <= force_nxt;
         irq_en    <= irq_en_nxt;
         armed     <= 1'b1;
         usb_rst_n <= usb_rst_n_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pulse_len <= PULSE_DEFAULT;
         wait_len  <= WAIT_DEFAULT;
      end else begin
         if (wr_pulse)
            pulse_len <= writedata[15:0];
         if (wr_wait)
            wait_len <= writedata[15:0];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[2:0]  = {irq_en, force_r, 1'b0};
         2'd1:    readdata[3:0]  = {state, done, busy};
         2'd2:    readdata[15:0] = pulse_len;
         default: readdata[15:0] = wait_len;
      endcase
   end

endmodule

// File: doc/usb_rst_sequencer.md
USB_RST_SEQUENCER -- requirements
Module: usb_rst_sequencer

Interface
REQ-001 SHALL have parameter PULSE_DEFAULT, default 16'd50000, reset value of PULSE_LEN.
REQ-002 SHALL have parameter WAIT_DEFAULT, default 16'd50000, reset value of WAIT_LEN.
REQ-003 SHALL have parameter AUTO_START, default 1, run one reset sequence automatically after reset_n release.
REQ-004 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port chipselect  in  1  Avalon-MM slave select.
REQ-007 SHALL have port address  in  2  register word index.
REQ-008 SHALL have port write_n  in  1  active-low write strobe, zero wait states.
REQ-009 SHALL have port writedata  in  32  write data.
REQ-010 SHALL have port readdata  out  32  combinational read data, read latency 0; unused bits 0.
REQ-011 SHALL have port usb_rst_n  out  1  registered active-low reset to the USB controller chip.
REQ-012 SHALL have port irq  out  1  level interrupt, equal to DONE & IRQ_EN.

Function
REQ-013 SHALL decode registers: 0 CTRL {bit2 IRQ_EN, bit1 FORCE, bit0 START}; 1 STATUS {bits3:2 state, bit1 DONE, bit0 BUSY}; 2 PULSE_LEN [15:0]; 3 WAIT_LEN [15:0].
REQ-014 SHALL accept a write when chipselect=1 and write_n=0, on that clk edge.
REQ-015 SHALL implement FSM IDLE(00) -> ASSERT(01) -> RECOVER(10) -> IDLE; 11 unused, decoded as IDLE.
REQ-016 SHALL, on accepted CTRL write with bit0=1 in IDLE, latch PULSE_LEN and WAIT_LEN into working counters, enter ASSERT and clear DONE on the same edge.
REQ-017 SHALL ignore START while BUSY (no restart, no counter reload, DONE unchanged).
REQ-018 SHALL read START as 0; START is not stored.
REQ-019 SHALL remain in ASSERT exactly max(PULSE_LEN,1) cycles, then in RECOVER exactly max(WAIT_LEN,1) cycles; a length of 0 is treated as 1.
REQ-020 SHALL use a 16-bit down-counter loaded with length-1; transition when counter is 0; no wrap-around.
REQ-021 SHALL, on the RECOVER->IDLE edge, set DONE (sticky).
REQ-022 SHALL clear DONE on an accepted STATUS write with bit1=1 (write-1-to-clear); START taking effect on the same edge also clears DONE.
REQ-023 SHALL, if DONE set and DONE-W1C occur on the same edge, leave DONE set.
REQ-024 SHALL drive BUSY = 1 in ASSERT or RECOVER.
REQ-025 SHALL register usb_rst_n from next-state: 0 when next state is ASSERT or FORCE=1 (next value), else 1; low for exactly the ASSERT cycles with FORCE=0.
REQ-026 SHALL let FORCE hold usb_rst_n low independently of the FSM; the FSM keeps sequencing unaffected.
REQ-027 SHALL apply writes to PULSE_LEN/WAIT_LEN at any time; a running sequence uses the latched values.

Reset
REQ-028 SHALL, while reset_n=0, hold: state IDLE, usb_rst_n=0, DONE=0, FORCE=0, IRQ_EN=0, irq=0, PULSE_LEN=PULSE_DEFAULT, WAIT_LEN=WAIT_DEFAULT, counter 0.
REQ-029 SHALL, on first edge after release with AUTO_START=1, enter ASSERT with default lengths as if START were written; with AUTO_START=0, stay IDLE and drive usb_rst_n=1.
REQ-030 SHALL abort any sequence on reset_n assertion mid-operation, with no DONE or irq.

Verification
REQ-031 SHALL verify: AUTO_START=0, PULSE_LEN=4, WAIT_LEN=3, write CTRL=0x1 -> usb_rst_n low exactly 4 cycles, BUSY high 7 cycles, then DONE=1, STATUS reads 0x2.
REQ-032 SHALL verify: IRQ_EN=1, sequence completes -> irq=1; write STATUS=0x2 -> irq=0 next cycle.
REQ-033 SHALL verify: PULSE_LEN=0, WAIT_LEN=0, START -> usb_rst_n low 1 cycle, BUSY 2 cycles.
REQ-034 SHALL verify: START again at cycle 2 of ASSERT, and PULSE_LEN=9 written mid-sequence -> pulse still 4 cycles, no restart; next START uses 9.
REQ-035 SHALL verify: FORCE=1 in IDLE -> usb_rst_n=0, BUSY=0; START with FORCE=1 -> DONE after 7 cycles, usb_rst_n stays 0 until FORCE=0.
REQ-036 SHALL verify: reset_n pulsed low during RECOVER -> usb_rst_n=0 immediately, DONE=0; AUTO_START=1 -> new 50000-cycle pulse follows.
